usb_rx_hex_decoder: RTL and testbench

- Consumer for the usb_serial rx byte stream; sits between usb_serial (rx_*/tx_* ports) and board LEDs in the receive-side test top.
- Parses host-typed ASCII lines of exactly two hex digits (e.g. "A5\n"), latches the decoded byte onto led, and answers each line over the tx stream with "OK\n" or "ER\n".
- Discards a partial line after an inactivity timeout.

---
 rtl/usb_rx_hex_decoder.sv | 180 ++++++++++++++++++
 tb/tb_usb_rx_hex_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_hex_decoder.sv
// Decodes host-typed two-hex-digit lines from the usb_serial rx stream onto led and answers OK or ER lines on tx.
// Optional echo of consumed bytes: define USB_RX_HEX_DECODER_ECHO_EN.
`timescale 1ns/1ps

module usb_rx_hex_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 48000000
) (
    input  logic       clk48mhz,
    input  logic       rst,
    input  logic       rx_tvalid,
    output logic       rx_tready,
    input  logic [7:0] rx_tdata,
    output logic       tx_tvalid,
    input  logic       tx_tready,
    output logic [7:0] tx_tdata,
    output logic [7:0] led,
    output logic       line_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        COLLECT,
        RESP
`ifdef USB_RX_HEX_DECODER_ECHO_EN
        , ECHO
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          rerr_q, rerr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    acc_q, acc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    led_d;
    logic          line_err_d;
    logic [7:0]    tx_tdata_d;
    logic          tx_tvalid_d;
    logic          rx_tready_d;
    logic          rx_hs, tx_hs;
    logic [4:0]    nib;

    // {is_hex, nibble}
    function automatic logic [4:0] hex_nib(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return {1'b1, 4'(b - 8'h30)};
        if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
        if (b >= 8'h61 && b <= 8'h66) return {1'b1, 4'(b - 8'h57)};
        return 5'b0_0000;
    endfunction

    function automatic logic [7:0] resp_byte(input logic is_err, input logic [1:0] idx);
        case (idx)
            2'd0:    return is_err ? 8'h45 : 8'h4F;
            2'd1:    return is_err ? 8'h52 : 8'h4B;
            default: return ASCII_LF;
        endcase
    endfunction

    always_ff @(posedge clk48mhz or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            idx_q     <= 2'd0;
            rerr_q    <= 1'b0;
            cnt_q     <= 2'd0;
            err_q     <= 1'b0;
            acc_q     <= 8'h00;
            tmo_q     <= '0;
            led       <= 8'h00;
            line_err  <= 1'b0;
            tx_tdata  <= 8'h00;
            tx_tvalid <= 1'b0;
            rx_tready <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rerr_q    <= rerr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            tmo_q     <= tmo_d;
            led       <= led_d;
            line_err  <= line_err_d;
            tx_tdata  <= tx_tdata_d;
            tx_tvalid <= tx_tvalid_d;
            rx_tready <= rx_tready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rerr_d     = rerr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        acc_d      = acc_q;
        tmo_d      = tmo_q;
        led_d      = led;
        line_err_d = 1'b0;
        tx_tdata_d = tx_tdata;
        rx_hs      = rx_tvalid && rx_tready;
        tx_hs      = tx_tvalid && tx_tready;
        nib        = hex_nib(rx_tdata);

        case (state_q)
            COLLECT: begin
                if (rx_hs) begin
                    tmo_d = '0;
                    if (nib[4]) begin
                        acc_d = {acc_q[3:0], nib[3:0]};
                        if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
`ifdef USB_RX_HEX_DECODER_ECHO_EN
                        state_d    = ECHO;
                        tx_tdata_d = rx_tdata;
`endif
                    end else if (rx_tdata == ASCII_LF) begin
                        cnt_d = 2'd0;
                        err_d = 1'b0;
                        acc_d = 8'h00;
                        idx_d = 2'd0;
                        if (cnt_q == 2'd2 && !err_q) begin
                            led_d      = acc_q;
                            state_d    = RESP;
                            rerr_d     = 1'b0;
                            tx_tdata_d = resp_byte(1'b0, 2'd0);
                        end else if (cnt_q != 2'd0 || err_q) begin
                            state_d    = RESP;
                            rerr_d     = 1'b1;
                            line_err_d = 1'b1;
                            tx_tdata_d = resp_byte(1'b1, 2'd0);
                        end
                    end else if (rx_tdata != ASCII_CR) begin
                        err_d = 1'b1;
`ifdef USB_RX_HEX_DECODER_ECHO_EN
                        state_d    = ECHO;
                        tx_tdata_d = rx_tdata;
`endif
                    end
                end else if ((cnt_q != 2'd0 || err_q) && TIMEOUT_CYCLES != 0) begin
                    // Stale partial line is dropped silently at terminal count
                    if (tmo_q == TMO_LAST) begin
                        cnt_d = 2'd0;
                        err_d = 1'b0;
                        acc_d = 8'h00;
                        tmo_d = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            RESP: begin
                if (tx_hs) begin
                    if (idx_q == 2'd2) begin
                        state_d = COLLECT;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        tx_tdata_d = resp_byte(rerr_q, idx_q + 2'd1);
                    end
                end
            end
`ifdef USB_RX_HEX_DECODER_ECHO_EN
            ECHO: begin
                if (tx_hs) state_d = COLLECT;
            end
`endif
            default: state_d = COLLECT;
        endcase

        tx_tvalid_d = (state_d != COLLECT);
        rx_tready_d = (state_d == COLLECT);
    end

endmodule

// File: tb/tb_usb_rx_hex_decoder.sv
// Bench for usb_rx_hex_decoder: directed and random lines against a line-level reference model.
// In line strings ';' stands for LF and '~' stands for CR.
`timescale 1ns/1ps

module tb_usb_rx_hex_decoder;

    typedef logic [7:0] bq_t[$];

`ifdef USB_RX_HEX_DECODER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk48mhz = 1'b0;
    logic       rst = 1'b1;
    logic       rx_tvalid = 1'b0;
    logic       rx_tready;
    logic [7:0] rx_tdata = 8'h00;
    logic       tx_tvalid;
    logic       tx_tready = 1'b0;
    logic [7:0] tx_tdata;
    logic [7:0] led;
    logic       line_err;

    usb_rx_hex_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk48mhz (clk48mhz),
        .rst      (rst),
        .rx_tvalid(rx_tvalid),
        .rx_tready(rx_tready),
        .rx_tdata (rx_tdata),
        .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready),
        .tx_tdata (tx_tdata),
        .led      (led),
        .line_err (line_err)
    );

    always #5 clk48mhz = ~clk48mhz;

    int         n_assert = 0;
    int         n_fail = 0;
    int         mode = 0;          // 0 stall, 1 ready, 2 toggle, 3 random
    bit         grant_once = 1'b0;
    bit         tog = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         cyc = 0;
    int         lerr_cnt = 0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         stamp_q[$];
    logic [7:0] led_exp = 8'h00;
    int         er_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // tx sink: drives tx_tready, records transfers, checks AXI hold and rx back-pressure
    always @(negedge clk48mhz) begin
        cyc++;
        if (rst) begin
            tx_tready  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(tx_tvalid), 32'd1);
                check("hold_data", 32'(tx_tdata), 32'(prev_data));
            end
            if (tx_tvalid) check("rx_backpressure", 32'(rx_tready), 32'd0);
            case (mode)
                1:       tx_tready = 1'b1;
                2:       begin tog = ~tog; tx_tready = tog; end
                3:       tx_tready = 1'($urandom_range(0, 1));
                default: tx_tready = 1'b0;
            endcase
            if (grant_once) begin
                tx_tready  = 1'b1;
                grant_once = 1'b0;
            end
            if (tx_tvalid && tx_tready) begin
                obs_q.push_back(tx_tdata);
                stamp_q.push_back(cyc);
            end
            prev_stall = tx_tvalid && !tx_tready;
            prev_data  = tx_tdata;
            if (line_err) lerr_cnt++;
        end
    end

    function automatic int nib_of(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h3B)      q.push_back(8'h0A);
            else if (s[i] == 8'h7E) q.push_back(8'h0D);
            else                    q.push_back(s[i]);
        end
        return q;
    endfunction

    // Reference: whole line in, expected tx bytes / led / error count out
    task automatic model_line(input bq_t l);
        int digits = 0;
        bit bad = 1'b0;
        int val = 0;
        for (int i = 0; i < l.size(); i++) begin
            if (l[i] == 8'h0A) begin
                if (digits == 2 && !bad) begin
                    led_exp = 8'(val);
                    exp_q.push_back(8'h4F); exp_q.push_back(8'h4B); exp_q.push_back(8'h0A);
                end else if (digits != 0 || bad) begin
                    er_exp++;
                    exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h0A);
                end
                digits = 0; bad = 1'b0; val = 0;
            end else begin
                if (ECHO && l[i] != 8'h0D) exp_q.push_back(l[i]);
                if (nib_of(l[i]) >= 0) begin
                    digits++;
                    val = (val * 16 + nib_of(l[i])) % 256;
                end else if (l[i] != 8'h0D) begin
                    bad = 1'b1;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        for (int t = 0; t < 500 && !done; t++) begin
            if (rx_tready) begin
                @(posedge clk48mhz);
                done = 1'b1;
            end
            @(negedge clk48mhz);
        end
        rx_tvalid = 1'b0;
        if (!done) check("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_q(input bq_t l);
        for (int i = 0; i < l.size(); i++) send_byte(l[i]);
    endtask

    task automatic run_line(input string s);
        bq_t q;
        q = str2q(s);
        model_line(q);
        send_q(q);
    endtask

    task automatic check_tx(input string tag, input bit consec);
        int n;
        for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk48mhz);
        repeat (4) @(negedge clk48mhz);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        n = stamp_q.size();
        if (consec && n >= 3) check({tag, "_consec"}, 32'(stamp_q[n-1] - stamp_q[n-3]), 32'd2);
        check({tag, "_led"}, 32'(led), 32'(led_exp));
        check({tag, "_line_err"}, 32'(lerr_cnt), 32'(er_exp));
        obs_q.delete();
        exp_q.delete();
        stamp_q.delete();
    endtask

    task automatic run_timeout(input int idle, input bit dropped);
        if (dropped) begin
            if (ECHO) exp_q.push_back(8'h42);
            model_line(str2q("C7;"));
        end else begin
            model_line(str2q("BC7;"));
        end
        send_byte(8'h42);
        repeat (idle) @(negedge clk48mhz);
        send_q(str2q("C7;"));
    endtask

    initial begin
        string hexs;
        string junk;
        string s;
        hexs = "0123456789ABCDEFabcdef";
        junk = "GZg !";

        rst = 1'b1;
        repeat (3) @(negedge clk48mhz);
        check("rst_rx_tready", 32'(rx_tready), 32'd0);
        check("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        check("rst_tx_tdata", 32'(tx_tdata), 32'h00);
        check("rst_led", 32'(led), 32'h00);
        check("rst_line_err", 32'(line_err), 32'd0);
        rst = 1'b0;
        @(negedge clk48mhz);
        check("post_rst_rx_tready", 32'(rx_tready), 32'd1);

        mode = 1;
        run_line("A5;");
        check("first_valid", 32'(tx_tvalid), 32'd1);
        check("first_byte", 32'(tx_tdata), 32'h4F);
        check_tx("a5", 1'b1);

        run_line("3c~;");
        check_tx("3c", 1'b1);
        run_line("7;");
        check_tx("short", 1'b1);

        run_line("1G;");
        run_line("123;");
        check_tx("bad", 1'b0);
        run_line(";");
        check_tx("empty", 1'b0);

        mode = 2;
        run_line("FF;");
        run_line("01;");
        check_tx("toggle", 1'b0);

        mode = 1;
        run_timeout(16, 1'b1);
        check_tx("timeout16", 1'b0);
        run_timeout(15, 1'b0);
        check_tx("timeout15", 1'b0);

        mode = 3;
        for (int k = 0; k < 24; k++) begin
            s = "";
            if ($urandom_range(0, 1) == 0) begin
                for (int j = 0; j < 2; j++) s = {s, hexs.substr($urandom_range(0, 21), 0)};
            end else begin
                for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                    case ($urandom_range(0, 7))
                        6:       s = {s, "~"};
                        7:       s = {s, junk.substr($urandom_range(0, 4), 0)};
                        default: s = {s, hexs.substr($urandom_range(0, 21), 0)};
                    endcase
                end
            end
            run_line({s, ";"});
            if (k % 6 == 5) check_tx("rand", 1'b0);
        end

        mode = 1;
        run_line("12");
        repeat (4) @(negedge clk48mhz);
        mode = 0;
        run_line(";");
        grant_once = 1'b1;
        for (int t = 0; t < 50 && obs_q.size() + 2 < exp_q.size(); t++) @(negedge clk48mhz);
        repeat (2) @(negedge clk48mhz);
        check("mid_resp_led", 32'(led), 32'h12);
        rst = 1'b1;
        #1;
        check("rst_mid_tx_tvalid", 32'(tx_tvalid), 32'd0);
        check("rst_mid_led", 32'(led), 32'h00);
        check("rst_mid_rx_tready", 32'(rx_tready), 32'd0);
        obs_q.delete();
        exp_q.delete();
        stamp_q.delete();
        led_exp = 8'h00;
        @(negedge clk48mhz);
        rst = 1'b0;
        mode = 1;
        @(negedge clk48mhz);
        check("rel_rx_tready", 32'(rx_tready), 32'd1);
        check("rel_tx_tvalid", 32'(tx_tvalid), 32'd0);
        run_line("5A;");
        check_tx("post_reset", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
